uart_rx_frame: RTL and testbench
================================

# uart_rx_frame

Serial receive front end for the UART peripheral. It synchronises the incoming line and detects start bits with 16x oversampling, then deserialises 5–8 data bits with optional parity and one or two stop bits. It presents each completed character to the register/FIFO block as `RxData` plus a one-cycle `RxDone` strobe, with the sampled stop bit (`RxStopBit`) and a parity error flag. It sits between the `rxd` pad and the register block's RX FIFO write port.

## Interface
Parameters:
- `OVERSAMPLE`, 16: baud ticks per bit. The value is fixed at 16; other values are unsupported.
- `SYNC_STAGES`, 2: flip-flops in the `rxd` synchroniser chain.

Ports:
- `pClk` in 1: the single clock. All logic is on the rising edge.
- `pReset` in 1: reset is synchronous and active-high.
- `RxEnable` in 1: receiver enable.
- `rxd` in 1: asynchronous serial line, idle high.
- `UBRR` in 12: baud divisor. The tick period is `UBRR+1` cycles.
- `DLS` in 2: data length is `5+DLS` bits.
- `STOP` in 1: 0 selects one stop bit, 1 selects two.
- `PEN` in 1: parity enable.
- `EPS` in 1: 1 selects even parity, 0 selects odd.
- `RxData` out 8: received character, right-justified, unused upper bits 0.
- `RxDone` out 1: one-cycle strobe marking a completed frame.
- `RxStopBit` out 1: AND of all sampled stop bits for the last frame.
- `RxParityErr` out 1: parity mismatch for the last frame. It is 0 when `PEN`=0.
- `RxBusy` out 1: high whenever the FSM is not in IDLE.

## Operation
- **Synchroniser.** `rxd` passes through the `SYNC_STAGES` flops to produce `rx_s`. A falling-edge detect on `rx_s` uses one extra registered copy.
- **Baud generator.** A 12-bit counter runs from 0 to `UBRR` and pulses `tick` for one cycle when the count equals `UBRR`, then wraps to 0. The counter is held at 0 while the FSM is in IDLE and starts counting on the cycle after start detection.
- **Configuration latch.** `UBRR`, `DLS`, `STOP`, `PEN` and `EPS` are latched on start detection. Changes to these inputs mid-frame have no effect on the current frame.
- **State machine states.**
  - IDLE: `RxBusy`=0. If `RxEnable`=1 and a falling edge is seen on `rx_s`, go to START.
  - START: count 8 ticks to reach mid-bit, then sample `rx_s`. If the sample is 1 (false start), go to IDLE with no `RxDone`. If 0, go to DATA.
  - DATA: sample every 16 ticks, LSB first, into a shift register. After `5+DLS` samples, go to PARITY if `PEN`=1, otherwise STOP1.
  - PARITY: sample after 16 ticks. Expected parity = XOR(data) when `EPS`=1, and ~XOR(data) when `EPS`=0. A mismatch sets the internal error bit.
  - STOP1: sample after 16 ticks. If `STOP`=1, go to STOP2; otherwise finish.
  - STOP2: sample after 16 ticks, then finish.
- **Finish.** On the cycle after the final stop sample:
  - `RxDone`=1 for exactly one cycle.
  - `RxData`, `RxStopBit` and `RxParityErr` update in that same cycle and hold until the next finish.
  - The FSM returns to IDLE in that same cycle. This lets the next start edge, which arrives half a bit later, be caught, so back-to-back frames are supported.
- **Framing errors.** A bad stop bit (`RxStopBit`=0) still produces `RxDone` and delivers data. Reporting the framing error is downstream's responsibility.
- **`RxEnable` deasserted.** Deasserting `RxEnable` in any non-IDLE state aborts to IDLE on the next cycle. There is no `RxDone`, outputs keep their previous values, and the baud counter clears.
- **Break line.** If `rxd` is held low through the stop sample, the frame completes with `RxStopBit`=0. The FSM then stays in IDLE until `rx_s` returns high and a new falling edge is seen.

## Timing
- **Reset values.** `RxData`=8'h00, `RxDone`=0, `RxStopBit`=1, `RxParityErr`=0, `RxBusy`=0. The FSM is in IDLE, the counters are 0, and the synchroniser and edge flops are preset to 1.
- **Reset mid-frame.** Reset returns the block to IDLE with the reset values above on the next edge, and no `RxDone` is issued.
- **Bit period.** One bit lasts `16*(UBRR+1)` cycles. With `UBRR`=0, one bit is 16 cycles.
- **Edge-to-IDLE latency.** The falling edge on `rxd` is seen at `rx_s` after `SYNC_STAGES` cycles and detected 1 cycle later. Start detection is at cycle S; the start sample is at S + 8·(UBRR+1).
- **Sample points.** Data bit k is sampled at S + (8+16(k+1))·(UBRR+1).
- **`RxDone` timing.** `RxDone` is asserted 1 cycle after the last stop sample.
- **Simultaneous events.**
  - `RxEnable` falling in the same cycle as the finish: the abort wins, with no `RxDone`.
  - A start edge in the same cycle as `RxDone`: ignored, because the FSM is not yet in IDLE. The edge detector compares against the registered `rx_s`, so a line still low is handled as under Break line.

## Test plan
- **8N1.** `UBRR`=0, `DLS`=3, `PEN`=0, `STOP`=0; send 0xA5 → one `RxDone` pulse, `RxData`=0xA5, `RxStopBit`=1, `RxParityErr`=0, `RxDone` 1 cycle after the stop sample at S+152.
- **5E2.** `DLS`=0, `PEN`=1, `EPS`=1, `STOP`=1; send 5'b10110 with parity 1 → `RxData`=0x16, `RxParityErr`=0. Resend with parity 0 → `RxParityErr`=1.
- **False start.** `UBRR`=3; a 3-cycle low glitch on `rxd` → the FSM returns to IDLE after the start sample, with no `RxDone`.
- **Framing error and break.** 8N1 with the stop bit forced 0 → `RxDone` with `RxStopBit`=0. Hold `rxd` low for 3 more frames → no further `RxDone` until `rxd` goes high and then low again.
- **Back-to-back.** Send 0x00, 0xFF, 0x55 with no idle gap, `UBRR`=1 → three `RxDone` pulses with the correct data, 320 cycles apart.
- **Abort.** Drop `RxEnable` during data bit 3 → `RxBusy`=0 next cycle, no `RxDone`, `RxData` unchanged. Re-enable and send 0x3C → received correctly. Assert `pReset` mid-frame → all outputs at reset values.

Source files
------------

// File: rtl/uart_rx_frame.sv
// UART receive front end: rxd synchroniser, 16x start detect and
// 5-8 bit deserialiser with optional parity and one or two stop bits.
module uart_rx_frame #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        pClk,
    input  logic        pReset,
    input  logic        RxEnable,
    input  logic        rxd,
    input  logic [11:0] UBRR,
    input  logic [1:0]  DLS,
    input  logic        STOP,
    input  logic        PEN,
    input  logic        EPS,
    output logic [7:0]  RxData,
    output logic        RxDone,
    output logic        RxStopBit,
    output logic        RxParityErr,
    output logic        RxBusy
);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2, DONE
    } rxState_t;

    localparam logic [3:0] LastTick = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MidTick  = 4'(OVERSAMPLE / 2 - 1);

    rxState_t               state;
    logic [SYNC_STAGES-1:0] syncReg;
    logic                   rxS;
    logic                   rxPrev;
    logic                   fall;
    logic [11:0]            baudCnt;
    logic                   tick;
    logic [3:0]             tickCnt;
    logic [2:0]             bitCnt;
    logic [2:0]             lastBit;
    logic [7:0]             shiftReg;
    logic                   parErr;
    logic                   stopAnd;
    logic [11:0]            ubrrL;
    logic [1:0]             dlsL;
    logic                   stopL;
    logic                   penL;
    logic                   epsL;

    assign rxS     = syncReg[SYNC_STAGES-1];
    assign fall    = rxPrev & ~rxS;
    assign tick    = (baudCnt == ubrrL);
    assign lastBit = 3'd4 + {1'b0, dlsL};
    assign RxBusy  = (state != IDLE);

    always_ff @(posedge pClk) begin
        if (pReset) begin
            syncReg <= '1;
            rxPrev  <= 1'b1;
        end else begin
            syncReg <= {syncReg[SYNC_STAGES-2:0], rxd};
            rxPrev  <= rxS;
        end
    end

    always_ff @(posedge pClk) begin
        if (pReset) begin
            state       <= IDLE;
            baudCnt     <= '0;
            tickCnt     <= '0;
            bitCnt      <= '0;
            shiftReg    <= '0;
            parErr      <= 1'b0;
            stopAnd     <= 1'b1;
            ubrrL       <= '0;
            dlsL        <= '0;
            stopL       <= 1'b0;
            penL        <= 1'b0;
            epsL        <= 1'b0;
            RxData      <= '0;
            RxDone      <= 1'b0;
            RxStopBit   <= 1'b1;
            RxParityErr <= 1'b0;
        end else begin
            RxDone <= 1'b0;
            if (state != IDLE && !RxEnable) begin
                // abort leaves the last delivered character untouched
                state   <= IDLE;
                baudCnt <= '0;
                tickCnt <= '0;
            end else begin
                if (state == IDLE || tick) begin
                    baudCnt <= '0;
                end else begin
                    baudCnt <= baudCnt + 12'd1;
                end
                unique case (state)
                    IDLE: begin
                        if (RxEnable && fall) begin
                            state    <= START;
                            tickCnt  <= '0;
                            bitCnt   <= '0;
                            shiftReg <= '0;
                            parErr   <= 1'b0;
                            stopAnd  <= 1'b1;
                            ubrrL    <= UBRR;
                            dlsL     <= DLS;
                            stopL    <= STOP;
                            penL     <= PEN;
                            epsL     <= EPS;
                        end
                    end
                    START: begin
                        if (tick) begin
                            if (tickCnt == MidTick) begin
                                tickCnt <= '0;
                                state   <= rxS ? IDLE : DATA;
                            end else begin
                                tickCnt <= tickCnt + 4'd1;
                            end
                        end
                    end
                    DATA: begin
                        if (tick) begin
                            if (tickCnt == LastTick) begin
                                tickCnt  <= '0;
                                shiftReg <= {rxS, shiftReg[7:1]};
                                bitCnt   <= bitCnt + 3'd1;
                                if (bitCnt == lastBit) begin
                                    state <= penL ? PARITY : STOP1;
                                end
                            end else begin
                                tickCnt <= tickCnt + 4'd1;
                            end
                        end
                    end
                    PARITY: begin
                        if (tick) begin
                            if (tickCnt == LastTick) begin
                                tickCnt <= '0;
                                parErr  <= rxS != (epsL ? ^shiftReg : ~^shiftReg);
                                state   <= STOP1;
                            end else begin
                                tickCnt <= tickCnt + 4'd1;
                            end
                        end
                    end
                    STOP1: begin
                        if (tick) begin
                            if (tickCnt == LastTick) begin
                                tickCnt <= '0;
                                stopAnd <= rxS;
                                state   <= stopL ? STOP2 : DONE;
                            end else begin
                                tickCnt <= tickCnt + 4'd1;
                            end
                        end
                    end
                    STOP2: begin
                        if (tick) begin
                            if (tickCnt == LastTick) begin
                                tickCnt <= '0;
                                stopAnd <= stopAnd & rxS;
                                state   <= DONE;
                            end else begin
                                tickCnt <= tickCnt + 4'd1;
                            end
                        end
                    end
                    DONE: begin
                        // data bits were shifted in from the top
                        RxData      <= shiftReg >> (3'd3 - {1'b0, dlsL});
                        RxStopBit   <= stopAnd;
                        RxParityErr <= parErr;
                        RxDone      <= 1'b1;
                        state       <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: drives serial frames bit by bit and checks
// each delivered character against values computed from the frame format.
module tb_uart_rx_frame;

    logic        pClk = 1'b0;
    logic        pReset;
    logic        RxEnable;
    logic        rxd;
    logic [11:0] UBRR;
    logic [1:0]  DLS;
    logic        STOP;
    logic        PEN;
    logic        EPS;
    logic [7:0]  RxData;
    logic        RxDone;
    logic        RxStopBit;
    logic        RxParityErr;
    logic        RxBusy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int frameStart;
    logic [7:0] lastData;

    logic [7:0] doneData[$];
    logic       doneStop[$];
    logic       doneErr[$];
    int         doneCyc[$];

    uart_rx_frame #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
        .pClk(pClk), .pReset(pReset), .RxEnable(RxEnable), .rxd(rxd),
        .UBRR(UBRR), .DLS(DLS), .STOP(STOP), .PEN(PEN), .EPS(EPS),
        .RxData(RxData), .RxDone(RxDone), .RxStopBit(RxStopBit),
        .RxParityErr(RxParityErr), .RxBusy(RxBusy)
    );

    always #5 pClk = ~pClk;
    always @(posedge pClk) cyc <= cyc + 1;

    always @(negedge pClk) begin
        if (RxDone === 1'b1) begin
            doneData.push_back(RxData);
            doneStop.push_back(RxStopBit);
            doneErr.push_back(RxParityErr);
            doneCyc.push_back(cyc);
        end
    end

    task automatic clear_log();
        doneData.delete();
        doneStop.delete();
        doneErr.delete();
        doneCyc.delete();
    endtask

    task automatic align();
        @(posedge pClk);
        #1;
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge pClk);
    endtask

    task automatic hold(input logic v, input int c);
        rxd = v;
        repeat (c) @(posedge pClk);
        #1;
    endtask

    task automatic set_cfg(input int u, input int dls, input bit stp,
                           input bit pen, input bit eps);
        UBRR = 12'(u);
        DLS  = 2'(dls);
        STOP = stp;
        PEN  = pen;
        EPS  = eps;
    endtask

    task automatic send_frame(input logic [7:0] d, input int n, input bit pen,
                              input bit par, input int nstop, input bit stopVal,
                              input int u, input bit scramble);
        int b;
        b = 16 * (u + 1);
        frameStart = cyc;
        hold(1'b0, b);
        if (scramble) begin
            UBRR = 12'($urandom);
            DLS  = 2'($urandom);
            STOP = 1'($urandom);
            PEN  = 1'($urandom);
            EPS  = 1'($urandom);
        end
        for (int i = 0; i < n; i++) hold(d[i], b);
        if (pen) hold(par, b);
        for (int i = 0; i < nstop; i++) hold(stopVal, b);
    endtask

    // cycle at which RxDone is seen for a frame whose start bit was driven at c0
    function automatic int done_at(input int c0, input int nbits, input int u);
        return c0 + 2 + 1 + (8 + 16 * nbits) * (u + 1) + 1;
    endfunction

    task automatic test_reset();
        pReset = 1'b1;
        RxEnable = 1'b1;
        rxd = 1'b1;
        set_cfg(0, 3, 0, 0, 0);
        repeat (3) @(posedge pClk);
        @(negedge pClk);
        checks++; if (RxData !== 8'h00) begin failures++; $display("FAIL reset_data got %h exp 00", RxData); end
        checks++; if (RxDone !== 1'b0) begin failures++; $display("FAIL reset_done got %b exp 0", RxDone); end
        checks++; if (RxStopBit !== 1'b1) begin failures++; $display("FAIL reset_stop got %b exp 1", RxStopBit); end
        checks++; if (RxParityErr !== 1'b0) begin failures++; $display("FAIL reset_perr got %b exp 0", RxParityErr); end
        checks++; if (RxBusy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", RxBusy); end
        pReset = 1'b0;
        lastData = 8'h00;
        repeat (4) @(posedge pClk);
    endtask

    task automatic test_8n1();
        int c0;
        clear_log();
        set_cfg(0, 3, 0, 0, 0);
        align();
        c0 = cyc;
        send_frame(8'hA5, 8, 0, 0, 1, 1, 0, 0);
        hold(1'b1, 20);
        checks++; if (doneData.size() !== 1) begin failures++; $display("FAIL 8n1_count got %0d exp 1", doneData.size()); end
        if (doneData.size() > 0) begin
            checks++; if (doneData[0] !== 8'hA5) begin failures++; $display("FAIL 8n1_data got %h exp a5", doneData[0]); end
            checks++; if (doneStop[0] !== 1'b1) begin failures++; $display("FAIL 8n1_stop got %b exp 1", doneStop[0]); end
            checks++; if (doneErr[0] !== 1'b0) begin failures++; $display("FAIL 8n1_perr got %b exp 0", doneErr[0]); end
            checks++; if (doneCyc[0] !== c0 + 156) begin failures++; $display("FAIL 8n1_time got %0d exp %0d", doneCyc[0] - c0, 156); end
        end
        lastData = 8'hA5;
    endtask

    task automatic test_5e2();
        logic [1:0] parv;
        parv = 2'b01;
        for (int k = 0; k < 2; k++) begin
            clear_log();
            set_cfg(0, 0, 1, 1, 1);
            align();
            send_frame(8'h16, 5, 1, parv[k], 2, 1, 0, 0);
            hold(1'b1, 20);
            checks++; if (doneData.size() !== 1) begin failures++; $display("FAIL 5e2_count par=%0d got %0d exp 1", parv[k], doneData.size()); end
            if (doneData.size() > 0) begin
                checks++; if (doneData[0] !== 8'h16) begin failures++; $display("FAIL 5e2_data got %h exp 16", doneData[0]); end
                checks++; if (doneErr[0] !== ~parv[k]) begin failures++; $display("FAIL 5e2_perr par=%0d got %b exp %b", parv[k], doneErr[0], ~parv[k]); end
            end
        end
        lastData = 8'h16;
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 10; f++) begin
            int u, dls, n, nstop, c0, nb;
            bit pen, eps, par, expErr;
            logic [7:0] d, expData;
            u = $urandom_range(0, 3);
            dls = $urandom_range(0, 3);
            n = 5 + dls;
            nstop = $urandom_range(1, 2);
            pen = 1'($urandom);
            eps = 1'($urandom);
            par = 1'($urandom);
            d = 8'($urandom);
            expData = 8'((int'(d)) % (1 << n));
            // even parity wants an even total count of ones, odd wants odd
            expErr = pen && ((($countones(expData) + int'(par)) % 2) != (eps ? 0 : 1));
            nb = n + (pen ? 1 : 0) + nstop;
            clear_log();
            set_cfg(u, dls, nstop == 2, pen, eps);
            align();
            c0 = cyc;
            send_frame(d, n, pen, par, nstop, 1, u, 1);
            hold(1'b1, 24);
            checks++; if (doneData.size() !== 1) begin failures++; $display("FAIL rnd%0d_count got %0d exp 1", f, doneData.size()); end
            if (doneData.size() > 0) begin
                checks++; if (doneData[0] !== expData) begin failures++; $display("FAIL rnd%0d_data got %h exp %h", f, doneData[0], expData); end
                checks++; if (doneErr[0] !== expErr) begin failures++; $display("FAIL rnd%0d_perr got %b exp %b", f, doneErr[0], expErr); end
                checks++; if (doneStop[0] !== 1'b1) begin failures++; $display("FAIL rnd%0d_stop got %b exp 1", f, doneStop[0]); end
                checks++; if (doneCyc[0] !== done_at(c0, nb, u)) begin failures++; $display("FAIL rnd%0d_time got %0d exp %0d", f, doneCyc[0] - c0, done_at(c0, nb, u) - c0); end
            end
            lastData = expData;
        end
    endtask

    task automatic test_false_start();
        int c0;
        clear_log();
        set_cfg(3, 3, 0, 0, 0);
        align();
        c0 = cyc;
        hold(1'b0, 3);
        rxd = 1'b1;
        wait_to(c0 + 34);
        checks++; if (RxBusy !== 1'b1) begin failures++; $display("FAIL fs_busy_before got %b exp 1", RxBusy); end
        wait_to(c0 + 35);
        checks++; if (RxBusy !== 1'b0) begin failures++; $display("FAIL fs_busy_after got %b exp 0", RxBusy); end
        repeat (200) @(posedge pClk);
        checks++; if (doneData.size() !== 0) begin failures++; $display("FAIL fs_done got %0d exp 0", doneData.size()); end
        checks++; if (RxData !== lastData) begin failures++; $display("FAIL fs_data got %h exp %h", RxData, lastData); end
    endtask

    task automatic test_break();
        clear_log();
        set_cfg(0, 3, 0, 0, 0);
        align();
        send_frame(8'h5A, 8, 0, 0, 1, 0, 0, 0);
        hold(1'b0, 480);
        checks++; if (doneData.size() !== 1) begin failures++; $display("FAIL brk_count got %0d exp 1", doneData.size()); end
        if (doneData.size() > 0) begin
            checks++; if (doneData[0] !== 8'h5A) begin failures++; $display("FAIL brk_data got %h exp 5a", doneData[0]); end
            checks++; if (doneStop[0] !== 1'b0) begin failures++; $display("FAIL brk_stop got %b exp 0", doneStop[0]); end
        end
        hold(1'b1, 40);
        send_frame(8'h81, 8, 0, 0, 1, 1, 0, 0);
        hold(1'b1, 20);
        checks++; if (doneData.size() !== 2) begin failures++; $display("FAIL brk_resume_count got %0d exp 2", doneData.size()); end
        if (doneData.size() > 1) begin
            checks++; if (doneData[1] !== 8'h81) begin failures++; $display("FAIL brk_resume_data got %h exp 81", doneData[1]); end
            checks++; if (doneStop[1] !== 1'b1) begin failures++; $display("FAIL brk_resume_stop got %b exp 1", doneStop[1]); end
        end
        lastData = 8'h81;
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [3];
        seq[0] = 8'h00;
        seq[1] = 8'hFF;
        seq[2] = 8'h55;
        clear_log();
        set_cfg(1, 3, 0, 0, 0);
        align();
        for (int i = 0; i < 3; i++) send_frame(seq[i], 8, 0, 0, 1, 1, 1, 0);
        hold(1'b1, 40);
        checks++; if (doneData.size() !== 3) begin failures++; $display("FAIL b2b_count got %0d exp 3", doneData.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < doneData.size()) begin
                checks++; if (doneData[i] !== seq[i]) begin failures++; $display("FAIL b2b_data%0d got %h exp %h", i, doneData[i], seq[i]); end
                if (i > 0) begin
                    checks++; if (doneCyc[i] - doneCyc[i-1] !== 320) begin failures++; $display("FAIL b2b_gap%0d got %0d exp 320", i, doneCyc[i] - doneCyc[i-1]); end
                end
            end
        end
        lastData = 8'h55;
    endtask

    task automatic test_abort();
        int c0;
        clear_log();
        set_cfg(0, 3, 0, 0, 0);
        align();
        c0 = cyc;
        fork
            send_frame(8'hC3, 8, 0, 0, 1, 1, 0, 0);
            begin
                wait_to(c0 + 69);
                checks++; if (RxBusy !== 1'b1) begin failures++; $display("FAIL abort_busy_before got %b exp 1", RxBusy); end
                RxEnable = 1'b0;
                @(negedge pClk);
                checks++; if (RxBusy !== 1'b0) begin failures++; $display("FAIL abort_busy_after got %b exp 0", RxBusy); end
            end
        join
        hold(1'b1, 40);
        checks++; if (doneData.size() !== 0) begin failures++; $display("FAIL abort_done got %0d exp 0", doneData.size()); end
        checks++; if (RxData !== lastData) begin failures++; $display("FAIL abort_data got %h exp %h", RxData, lastData); end
        RxEnable = 1'b1;
        hold(1'b1, 8);
        send_frame(8'h3C, 8, 0, 0, 1, 1, 0, 0);
        hold(1'b1, 20);
        checks++; if (doneData.size() !== 1) begin failures++; $display("FAIL reen_count got %0d exp 1", doneData.size()); end
        if (doneData.size() > 0) begin
            checks++; if (doneData[0] !== 8'h3C) begin failures++; $display("FAIL reen_data got %h exp 3c", doneData[0]); end
        end
        lastData = 8'h3C;
    endtask

    task automatic test_reset_mid();
        int c0;
        clear_log();
        set_cfg(0, 3, 0, 0, 0);
        align();
        c0 = cyc;
        fork
            send_frame(8'hFF, 8, 0, 0, 1, 1, 0, 0);
            begin
                wait_to(c0 + 50);
                checks++; if (RxBusy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got %b exp 1", RxBusy); end
                pReset = 1'b1;
                @(negedge pClk);
                pReset = 1'b0;
                checks++; if (RxBusy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got %b exp 0", RxBusy); end
                checks++; if (RxData !== 8'h00) begin failures++; $display("FAIL rstmid_data got %h exp 00", RxData); end
                checks++; if (RxStopBit !== 1'b1) begin failures++; $display("FAIL rstmid_stop got %b exp 1", RxStopBit); end
                checks++; if (RxParityErr !== 1'b0) begin failures++; $display("FAIL rstmid_perr got %b exp 0", RxParityErr); end
            end
        join
        hold(1'b1, 40);
        checks++; if (doneData.size() !== 0) begin failures++; $display("FAIL rstmid_done got %0d exp 0", doneData.size()); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_5e2();
        test_random_frames();
        test_false_start();
        test_break();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
